// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit shifter.
// - spi_state_e : frame sequencing states (idle, shifting, ss hold, ss-high gap)
// - params_ok   : legality check for WIDTH / HALF / SS_GAP, used at elaboration
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StGap
  } spi_state_e;

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned half,
                                   input int unsigned ss_gap);
    return (width >= 1) && (width <= 32) && (half >= 1) && (ss_gap >= 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_en    : count while high
//   i_clr   : synchronous clear (wins over i_en)
//   o_tick  : one-cycle pulse on the last system clock of each HALF-cycle period
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned HALF = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(HALF + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF - 1);

  if (!params_ok(1, HALF, 1)) begin : g_param_check
    $error("spi_clk_div: HALF must be >= 1");
  end

  logic [CntW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = i_en && (r_cnt == CntLast);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 transmit master: serialises a parallel word MSB-first on sclk/sdo
// under an active-low slave select, then keeps ss high for a minimum gap.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_req, i_dat   : transfer request (sampled only while idle) and word
//   o_busy         : high from the cycle after acceptance until the gap expires
//   o_snt          : one-cycle pulse when the frame closes (same cycle ss rises)
//   o_sclk, o_ss, o_sdo : serial clock (idles low), slave select, data out
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HALF   = 2,
  parameter int unsigned SS_GAP = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_busy,
  output logic             o_snt,
  output logic             o_sclk,
  output logic             o_ss,
  output logic             o_sdo
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned GapW = $clog2(SS_GAP + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(SS_GAP - 1);

  if (!params_ok(WIDTH, HALF, SS_GAP)) begin : g_param_check
    $error("spi_tx_shifter: need 1 <= WIDTH <= 32, HALF >= 1, SS_GAP >= 1");
  end

  spi_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic [BitW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [GapW-1:0]  r_gap_cnt, w_gap_cnt_nxt;

  logic w_tick;
  logic w_div_en;
  logic w_div_clr;

  // Divider is held clear while idle so the first tick lands HALF cycles after ss falls.
  assign w_div_en  = (r_state == StShift) || (r_state == StHold);
  assign w_div_clr = (r_state == StIdle);

  spi_clk_div #(
    .HALF (HALF)
  ) u_clk_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_div_en),
    .i_clr   (w_div_clr),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_sclk_nxt    = r_sclk;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          w_state_nxt   = StShift;
          w_shift_nxt   = i_dat;
          w_sclk_nxt    = 1'b0;
          w_bit_cnt_nxt = '0;
        end
      end
      StShift: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            // Last falling edge leaves the LSB on sdo through the hold phase.
            if (r_bit_cnt == BitLast) begin
              w_state_nxt = StHold;
            end else begin
              w_shift_nxt   = r_shift << 1;
              w_bit_cnt_nxt = r_bit_cnt + BitW'(1);
            end
          end
        end
      end
      StHold: begin
        if (w_tick) begin
          w_state_nxt   = StGap;
          w_shift_nxt   = '0;
          w_gap_cnt_nxt = '0;
        end
      end
      StGap: begin
        if (r_gap_cnt == GapLast) begin
          w_state_nxt = StIdle;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GapW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_sclk    <= w_sclk_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  assign o_ss   = !((r_state == StShift) || (r_state == StHold));
  assign o_busy = (r_state != StIdle);
  assign o_snt  = (r_state == StGap) && (r_gap_cnt == '0);
  assign o_sclk = r_sclk;
  assign o_sdo  = r_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_tx_shifter.sv
module tb_spi_tx_shifter;

  localparam int W8 = 8;
  localparam int H8 = 2;
  localparam int G8 = 2;
  localparam int FRAME8 = 1 + (2 * W8 + 1) * H8; // acceptance to snt

  logic clk;
  logic rst_n, rst16_n;
  logic req8, req16;
  logic [7:0] dat8;
  logic [15:0] dat16;
  logic busy8, snt8, sclk8, ss8, sdo8;
  logic busy16, snt16, sclk16, ss16, sdo16;

  int cyc;
  int n_chk;
  int n_err;

  spi_tx_shifter #(.WIDTH(8), .HALF(2), .SS_GAP(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req8),
    .i_dat   (dat8),
    .o_busy  (busy8),
    .o_snt   (snt8),
    .o_sclk  (sclk8),
    .o_ss    (ss8),
    .o_sdo   (sdo8)
  );

  spi_tx_shifter #(.WIDTH(16), .HALF(1), .SS_GAP(2)) dut16 (
    .i_clk   (clk),
    .i_rst_n (rst16_n),
    .i_req   (req16),
    .i_dat   (dat16),
    .o_busy  (busy16),
    .o_snt   (snt16),
    .o_sclk  (sclk16),
    .o_ss    (ss16),
    .o_sdo   (sdo16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: a request is accepted when the block is free; each frame then
  // occupies the link for FRAME8 + SS_GAP cycles from its acceptance.
  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   m_next;
  int   n_acc;

  initial begin
    m_next = 0;
    n_acc  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_next = 0;
      end else if (req8 && cyc >= m_next) begin
        exp_q.push_back('{d: dat8, acc: cyc});
        m_next = cyc + FRAME8 + G8;
        n_acc++;
      end
    end
  end

  // Monitor: deserialise on sclk rising edges and compare each closed frame.
  initial begin
    logic       p_ss, p_sclk;
    logic [7:0] word;
    int         edges;
    int         busy_cyc;
    exp_t       e;
    p_ss = 1'b1; p_sclk = 1'b0; word = '0; edges = 0; busy_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ss = 1'b1; p_sclk = 1'b0; edges = 0; busy_cyc = -1;
      end else begin
        if (busy_cyc >= 0) begin
          if (cyc == busy_cyc - 1) chk("busy_in_gap", busy8, 1'b1);
          if (cyc == busy_cyc) begin
            chk("busy_after_gap", busy8, 1'b0);
            busy_cyc = -1;
          end
        end
        if (!ss8 && p_ss) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_start", 1, 0);
          end else begin
            chk("ss_fall_cycle", cyc, exp_q[0].acc + 1);
            chk("busy_at_start", busy8, 1'b1);
          end
          word = '0;
          edges = 0;
        end
        if (sclk8 && !p_sclk) begin
          word = {word[6:0], sdo8};
          edges++;
        end
        if (snt8) begin
          if (exp_q.size() == 0) begin
            chk("spurious_snt", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", word, e.d);
            chk("snt_cycle", cyc, e.acc + FRAME8);
            chk("rising_edges", edges, W8);
            chk("ss_at_snt", ss8, 1'b1);
            busy_cyc = cyc + G8;
          end
        end
        p_ss = ss8;
        p_sclk = sclk8;
      end
    end
  end

  // sclk must never be high with ss high, and ss must not change right after sclk was high.
  initial begin
    logic p_ss, p_sclk, q_ss, q_sclk;
    p_ss = 1'b1; p_sclk = 1'b0; q_ss = 1'b1; q_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("sclk_high_with_ss_high", ss8 & sclk8, 1'b0);
        if (p_sclk) chk("ss_toggle_sclk_high", ss8, p_ss);
      end
      if (rst16_n) begin
        chk("sclk16_high_with_ss_high", ss16 & sclk16, 1'b0);
        if (q_sclk) chk("ss16_toggle_sclk_high", ss16, q_ss);
      end
      p_ss = ss8; p_sclk = sclk8; q_ss = ss16; q_sclk = sclk16;
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    int target;
    int budget;
    logic [15:0] stream;
    int edges16;
    int snt16_c;
    logic odd_ok;
    logic prev16;

    n_chk = 0; n_err = 0;
    req8 = 1'b0; dat8 = '0; req16 = 1'b0; dat16 = '0;
    rst_n = 1'b0; rst16_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; rst16_n = 1'b1;
    #1;
    chk("reset_ss", ss8, 1'b1);
    chk("reset_sclk", sclk8, 1'b0);
    chk("reset_sdo", sdo8, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_snt", snt8, 1'b0);
    chk("reset_ss16", ss16, 1'b1);

    // Single frame 0xA5 with an ignored request mid-frame.
    @(posedge clk); #1;
    t = cyc; req8 = 1'b1; dat8 = 8'hA5;
    @(posedge clk); #1;
    req8 = 1'b0; dat8 = 8'h3C;
    chk("first_ss_low", ss8, 1'b0);
    chk("first_busy", busy8, 1'b1);
    chk("first_sdo_msb", sdo8, 1'b1);
    goto(t + 10);
    req8 = 1'b1; dat8 = 8'hFF;
    @(posedge clk); #1;
    req8 = 1'b0;
    goto(t + 34);
    chk("ss_low_before_end", ss8, 1'b0);
    goto(t + 35);
    chk("snt_at_35", snt8, 1'b1);
    goto(t + 36);
    chk("snt_one_cycle", snt8, 1'b0);
    goto(t + 37);
    chk("busy_low_37", busy8, 1'b0);

    // Back-to-back frames with req held high.
    goto(t + 40);
    t = cyc; req8 = 1'b1; dat8 = 8'h01;
    @(posedge clk); #1;
    dat8 = 8'h80;
    goto(t + 34);
    chk("b2b_ss_low_34", ss8, 1'b0);
    goto(t + 37);
    chk("b2b_ss_high_37", ss8, 1'b1);
    goto(t + 38);
    chk("b2b_second_start_38", ss8, 1'b0);
    req8 = 1'b0;
    goto(t + 38 + 40);

    // Reset in the middle of a frame.
    t = cyc; req8 = 1'b1; dat8 = 8'hC3;
    @(posedge clk); #1;
    req8 = 1'b0;
    goto(t + 15);
    rst_n = 1'b0;
    #1;
    chk("midreset_ss", ss8, 1'b1);
    chk("midreset_sclk", sclk8, 1'b0);
    chk("midreset_sdo", sdo8, 1'b0);
    chk("midreset_busy", busy8, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    goto(t + 40);
    t = cyc; req8 = 1'b1; dat8 = 8'h5A;
    @(posedge clk); #1;
    req8 = 1'b0;
    chk("post_reset_ss_low", ss8, 1'b0);
    goto(t + 40);

    // WIDTH=16, HALF=1 instance.
    t = cyc; req16 = 1'b1; dat16 = 16'h0C01;
    @(posedge clk); #1;
    req16 = 1'b0;
    stream = '0; edges16 = 0; snt16_c = -1; odd_ok = 1'b1; prev16 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sclk16 && !prev16) begin
        stream = {stream[14:0], sdo16};
        edges16++;
        if (((cyc - (t + 1)) % 2) != 1) odd_ok = 1'b0;
      end
      prev16 = sclk16;
      if (snt16) snt16_c = cyc;
    end
    chk("w16_stream", stream, 16'h0C01);
    chk("w16_edges", edges16, 16);
    chk("w16_odd_offsets", odd_ok, 1'b1);
    chk("w16_snt_cycle", snt16_c, t + 34);

    // 1000 back-to-back frames with random data changing every cycle.
    @(posedge clk); #1;
    target = n_acc + 1000;
    budget = 1000 * (FRAME8 + G8 + 1) + 100;
    req8 = 1'b1; dat8 = 8'($urandom);
    while (n_acc < target && budget > 0) begin
      @(posedge clk); #1;
      dat8 = 8'($urandom);
      budget--;
    end
    req8 = 1'b0;
    if (budget == 0) chk("random_accept_timeout", n_acc, target);
    budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
